// File: rtl/mem_access_pkg.sv
// Shared types and decode helpers for the load/store engine.
// MEM_ACCESS_LWLR_EN enables the unaligned LWL/LWR merge loads.
package mem_access_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } mem_op_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE,
        ERR
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    function automatic logic is_load(input logic [3:0] op);
        return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        if (op inside {LH, LHU, SH}) return lo[0];
        if (op inside {LW, SW})      return lo != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic is_supported(input logic [3:0] op);
`ifdef MEM_ACCESS_LWLR_EN
        return op <= SW;
`else
        return (op <= SW) && !(op inside {LWL, LWR});
`endif
    endfunction

    function automatic logic [3:0] byte_enable(input logic [3:0] op, input logic [1:0] lo);
        if (op inside {LB, LBU, SB}) return 4'b0001 << lo;
        if (op inside {LH, LHU, SH}) return lo[1] ? BE_HALF_HI : BE_HALF_LO;
        return BE_WORD;
    endfunction

    // Replicate the store datum across every lane it could occupy.
    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wdata);
        if (op == SB) return {4{wdata[7:0]}};
        if (op == SH) return {2{wdata[15:0]}};
        return wdata;
    endfunction

endpackage

// File: rtl/mem_load_format.sv
// Combinational lane extraction and sign/zero extension of a read word.
// With MEM_ACCESS_LWLR_EN, also merges LWL/LWR results with the old rt value.
module mem_load_format
    import mem_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(word >> {addr_lo, 3'b000});
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

`ifdef MEM_ACCESS_LWLR_EN
    logic [4:0] lwl_sh;
    logic [4:0] lwr_sh;

    // LWL shifts by 8*(3-k); ~k equals 3-k for a two-bit k.
    assign lwl_sh = {~addr_lo, 3'b000};
    assign lwr_sh = {addr_lo, 3'b000};
`else
    logic unused_rt_old;
    assign unused_rt_old = ^rt_old;
`endif

    always_comb begin
        result = word;
        case (mem_op_t'(op))
            LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LBU: result = {24'd0, byte_sel};
            LH:  result = {{16{half_sel[15]}}, half_sel};
            LHU: result = {16'd0, half_sel};
`ifdef MEM_ACCESS_LWLR_EN
            LWL: result = (word << lwl_sh) | (rt_old & ~(32'hFFFF_FFFF << lwl_sh));
            LWR: result = (word >> lwr_sh) | (rt_old & ~(32'hFFFF_FFFF >> lwr_sh));
`endif
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-request load/store engine driving a word-aligned Avalon master port.
// LWL/LWR are only accepted when MEM_ACCESS_LWLR_EN is defined.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rt_old,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rt_old_q;
    logic [31:0] load_result;

    mem_load_format u_format (
        .op      (op_q),
        .addr_lo (addr_lo_q),
        .word    (avm_readdata),
        .rt_old  (rt_old_q),
        .result  (load_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= 4'd0;
            addr_lo_q      <= 2'd0;
            rt_old_q       <= 32'd0;
            done           <= 1'b0;
            err            <= 1'b0;
            rdata          <= 32'd0;
            avm_address    <= RESET_ADDR;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= 4'd0;
            avm_writedata  <= 32'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state_q)
                // ERR is already a completed request, so it accepts start like IDLE.
                IDLE, ERR: begin
                    state_q <= IDLE;
                    if (start) begin
                        op_q      <= op;
                        addr_lo_q <= addr[1:0];
                        rt_old_q  <= rt_old;
                        if (!is_supported(op) || is_misaligned(op, addr[1:0])) begin
                            state_q <= ERR;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            avm_address    <= {addr[31:2], 2'b00};
                            avm_byteenable <= byte_enable(op, addr[1:0]);
                            if (is_load(op)) begin
                                state_q  <= READ;
                                avm_read <= 1'b1;
                            end else begin
                                state_q       <= WRITE;
                                avm_write     <= 1'b1;
                                avm_writedata <= store_data(op, wdata);
                            end
                        end
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state_q  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rdata          <= load_result;
                    done           <= 1'b1;
                    state_q        <= IDLE;
                    avm_address    <= RESET_ADDR;
                    avm_byteenable <= 4'd0;
                end
                WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write      <= 1'b0;
                        done           <= 1'b1;
                        state_q        <= IDLE;
                        avm_address    <= RESET_ADDR;
                        avm_byteenable <= 4'd0;
                        avm_writedata  <= 32'd0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a word-array memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rt_old = 32'd0;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] init_words [16];
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata;
    logic        mem_load = 1'b1;
    int          stall_req = 0;
    int          stall_cnt = 0;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .op              (op),
        .addr            (addr),
        .wdata           (wdata),
        .rt_old          (rt_old),
        .done            (done),
        .err             (err),
        .rdata           (rdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt != 0);

    // Registered Avalon RAM: read data appears the cycle after the accepted read.
    always @(posedge clk) begin
        logic [31:0] tmp;
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_words[i];
        end else if (avm_write && !avm_waitrequest) begin
            tmp = mem[avm_address[5:2]];
            for (int j = 0; j < 4; j++)
                if (avm_byteenable[j]) tmp[8*j +: 8] = avm_writedata[8*j +: 8];
            mem[avm_address[5:2]] <= tmp;
        end
        if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address[5:2]];
        if (!(avm_read || avm_write)) stall_cnt <= stall_req;
        else if (stall_cnt != 0)      stall_cnt <= stall_cnt - 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model, written from the architectural rules.
    function automatic bit m_is_load(input logic [3:0] o);
        return o inside {LB, LBU, LH, LHU, LW, LWL, LWR};
    endfunction

    function automatic bit m_err(input logic [3:0] o, input logic [31:0] a);
        if (o > 4'd9) return 1'b1;
`ifndef MEM_ACCESS_LWLR_EN
        if (o == LWL || o == LWR) return 1'b1;
`endif
        if ((o == LH || o == LHU || o == SH) && a[0]) return 1'b1;
        if ((o == LW || o == SW) && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] o, input logic [31:0] a);
        int k = int'(a[1:0]);
        if (o == LB || o == LBU || o == SB) return 4'(1 << k);
        if (o == LH || o == LHU || o == SH) return (k >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] w, input logic [31:0] rto);
        int k = int'(a[1:0]);
        logic [7:0]  b = 8'((w >> (8 * k)) & 32'hFF);
        logic [15:0] h = 16'((w >> ((k >= 2) ? 16 : 0)) & 32'hFFFF);
        int sh = 8 * (3 - k);
        case (o)
            LB:  return 32'($signed(b));
            LBU: return 32'(b);
            LH:  return 32'($signed(h));
            LHU: return 32'(h);
            LWL: return (w << sh) | (rto & 32'((64'd1 << sh) - 64'd1));
            LWR: return (w >> (8 * k)) | (rto & ~(32'hFFFF_FFFF >> (8 * k)));
            default: return w;
        endcase
    endfunction

    // Issue one request, then watch the bus each cycle until done or the budget runs out.
    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rto, input int stall, input logic [31:0] ea,
                         input logic [3:0] eb, input logic [31:0] ew, output int lat,
                         output logic e, output int rd_cyc, output int wr_cyc,
                         output bit bus_ok);
        stall_req = stall;
        lat = 0; e = 1'bx; rd_cyc = 0; wr_cyc = 0; bus_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; addr = a; wdata = wd; rt_old = rto;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (avm_read && avm_write) bus_ok = 1'b0;
            if (avm_read) begin
                rd_cyc++;
                if (avm_address !== ea || avm_byteenable !== eb) bus_ok = 1'b0;
            end
            if (avm_write) begin
                wr_cyc++;
                if (avm_address !== ea || avm_byteenable !== eb || avm_writedata !== ew)
                    bus_ok = 1'b0;
            end
            if (done === 1'b1) begin
                lat = c;
                e = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic exec(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rto, input int stall);
        bit e_exp, ld, st, bus_ok;
        logic [31:0] w, ew, tmp;
        logic [3:0] eb;
        int lat, rd_cyc, wr_cyc, k;
        logic e;
        e_exp = m_err(o, a);
        ld = !e_exp && m_is_load(o);
        st = !e_exp && !m_is_load(o);
        w = ref_mem[a[5:2]];
        eb = m_be(o, a);
        k = int'(a[1:0]);
        ew = (o == SB) ? {4{wd[7:0]}} : (o == SH) ? {2{wd[15:0]}} : wd;
        do_op(o, a, wd, rto, stall, {a[31:2], 2'b00}, eb, ew, lat, e, rd_cyc, wr_cyc, bus_ok);
        if (ld) exp_rdata = m_load(o, a, w, rto);
        if (st) begin
            tmp = w;
            if (o == SB) tmp[8*k +: 8] = wd[7:0];
            else if (o == SH) tmp[(k >= 2 ? 16 : 0) +: 16] = wd[15:0];
            else tmp = wd;
            ref_mem[a[5:2]] = tmp;
        end
        chk({tag, ".latency"}, lat, e_exp ? 1 : ld ? 3 + stall : 2 + stall);
        chk({tag, ".err"}, 32'(e), 32'(e_exp));
        chk({tag, ".rdata"}, rdata, exp_rdata);
        chk({tag, ".read_cycles"}, rd_cyc, ld ? 1 + stall : 0);
        chk({tag, ".write_cycles"}, wr_cyc, st ? 1 + stall : 0);
        chk({tag, ".bus"}, 32'(bus_ok), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) init_words[i] = $urandom;
        init_words[1] = 32'h8899_AABB;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_words[i];
        exp_rdata = 32'd0;

        repeat (3) @(negedge clk);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.read", 32'(avm_read), 32'd0);
        chk("reset.write", 32'(avm_write), 32'd0);
        chk("reset.byteenable", 32'(avm_byteenable), 32'd0);
        chk("reset.writedata", avm_writedata, 32'd0);
        chk("reset.address", avm_address, 32'hBFC0_0000);
        reset = 1'b0;
        mem_load = 1'b0;

        exec("lw", LW, 32'hBFC0_0004, 32'd0, 32'd0, 0);
        chk("lw.const", rdata, 32'h8899_AABB);
        chk("idle.address", avm_address, 32'hBFC0_0000);
        exec("lb", LB, 32'hBFC0_0007, 32'd0, 32'd0, 0);
        chk("lb.const", rdata, 32'hFFFF_FF88);
        exec("lbu", LBU, 32'hBFC0_0007, 32'd0, 32'd0, 0);
        chk("lbu.const", rdata, 32'h0000_0088);
        exec("lh", LH, 32'hBFC0_0006, 32'd0, 32'd0, 0);
        chk("lh.const", rdata, 32'hFFFF_8899);
        exec("lhu", LHU, 32'hBFC0_0004, 32'd0, 32'd0, 0);
        chk("lhu.const", rdata, 32'h0000_AABB);

        exec("sb", SB, 32'hBFC0_0009, 32'h1234_5678, 32'd0, 0);
        exec("sb.readback", LW, 32'hBFC0_0008, 32'd0, 32'd0, 0);
        chk("sb.byte1", 32'(rdata[15:8]), 32'h78);

        exec("lw.stall3", LW, 32'hBFC0_0004, 32'd0, 32'd0, 3);
        exec("lh.misaligned", LH, 32'hBFC0_0005, 32'd0, 32'd0, 0);
        exec("sw.misaligned", SW, 32'hBFC0_0002, 32'hDEAD_BEEF, 32'd0, 0);
        exec("illegal", 4'd12, 32'hBFC0_0000, 32'd0, 32'd0, 0);
        exec("lwl", LWL, 32'hBFC0_0005, 32'd0, 32'h1122_3344, 0);
`ifdef MEM_ACCESS_LWLR_EN
        chk("lwl.const", rdata, 32'hAABB_3344);
`endif
        exec("lwr", LWR, 32'hBFC0_0005, 32'd0, 32'h1122_3344, 0);
`ifdef MEM_ACCESS_LWLR_EN
        chk("lwr.const", rdata, 32'h1188_99AA);
`endif

        // Abort a stalled store with reset; the memory must stay untouched.
        stall_req = 10;
        @(negedge clk);
        start = 1'b1; op = SW; addr = 32'hBFC0_0010; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("abort.write_before", 32'(avm_write), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.write_after", 32'(avm_write), 32'd0);
        chk("abort.done_after", 32'(done), 32'd0);
        reset = 1'b0;
        exp_rdata = 32'd0;
        exec("abort.readback", LW, 32'hBFC0_0010, 32'd0, 32'd0, 0);
        exec("sw.after_abort", SW, 32'hBFC0_0010, 32'h0BAD_CAFE, 32'd0, 1);
        exec("sw.readback", LW, 32'hBFC0_0010, 32'd0, 32'd0, 0);
        chk("sw.const", rdata, 32'h0BAD_CAFE);

        for (int i = 0; i < 60; i++) begin
            exec("random", 4'($urandom_range(0, 11)), 32'hBFC0_0000 + 32'($urandom_range(0, 63)),
                 $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store engine sitting directly upstream of the Avalon data memory; the memory side is the testbench RAM model or the real bus.
- Takes one load/store request from the datapath and emits a single word-aligned Avalon read or write with the correct byteenable and lane-replicated writedata.
- Honours waitrequest; extracts, sign/zero-extends and returns load data with a one-cycle done pulse.
- Bus is little-endian: byte address base+k maps to lane k, which is bits [8k+7:8k] and byteenable[k].

Parameters:
- RESET_ADDR, 32'hBFC00000, value driven on `avm_address` while idle; no functional effect.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  4  mem_op_t operation code
- addr  in  32  byte address
- wdata  in  32  store data (rt)
- rt_old  in  32  current rt value, for LWL/LWR merge
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; misaligned or illegal op
- rdata  out  32  formatted load result, held until the next load completes
- avm_address  out  32  {addr[31:2],2'b00}
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_byteenable  out  4  lane enables
- avm_writedata  out  32  lane-replicated store data
- avm_readdata  in  32  valid the cycle after read is accepted (registered memory)
- avm_waitrequest  in  1  stall

Behaviour:
- Reset: state IDLE. Zero outputs: done, err, rdata, avm_read, avm_write, avm_byteenable, avm_writedata. avm_address = RESET_ADDR.
- Reset mid-transaction aborts it: read/write drop on the next cycle and no done is issued.
- States and transitions:
  - IDLE: start=1 → latch op, addr, wdata, rt_old.
    - Misaligned or illegal op → ERR.
    - Load → READ.
    - Store → WRITE.
  - READ: avm_read=1; address and byteenable held stable while waitrequest=1; edge with waitrequest=0 → CAPTURE.
  - CAPTURE: avm_readdata valid; register formatted value into rdata, assert done=1 next cycle → IDLE.
  - WRITE: avm_write=1 with stable address, byteenable and writedata; edge with waitrequest=0 → done=1 next cycle → IDLE.
  - ERR: done=1 and err=1 next cycle, no bus activity, rdata unchanged → IDLE.
- done and err are registered and high exactly one cycle. err=0 on normal completion.
- A new start may be sampled in the same cycle done is high (state is already IDLE). start outside IDLE is ignored.
- Latency from the start edge to the done cycle, with zero wait states: load 3 cycles, store 2 cycles, error 1 cycle. Each waitrequest cycle adds 1.
- Byteenable:
  - LB, LBU, SB: 1<<addr[1:0].
  - LH, LHU, SH: addr[1] ? 4'b1100 : 4'b0011.
  - LW, SW, LWL, LWR: 4'b1111.
- Writedata: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load format:
  - LB/LBU: lane addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword at lane pair addr[1], sign- or zero-extended.
  - LW: whole word.
- Misaligned: halfword ops with addr[0]=1; word ops (LW, SW) with addr[1:0]≠0.
- Illegal: any undefined op code.
- read and write are never asserted together.

Optional Feature:
- Macro: MEM_ACCESS_LWLR_EN.
- Defined: LWL and LWR supported; never misaligned. With k=addr[1:0]:
  - LWL: rdata = (word << 8*(3-k)) | (rt_old & ((1<<8*(3-k))-1)).
  - LWR: rdata = (word >> 8*k) | (rt_old & ~(32'hFFFFFFFF >> 8*k)).
- Undefined: LWL/LWR take the ERR path with err=1 and no bus access.

Decomposition:
- Package mem_access_pkg:
  - mem_op_t: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
  - state_t: IDLE, READ, CAPTURE, WRITE, ERR.
  - Byteenable constants BE_WORD, BE_HALF_LO, BE_HALF_HI.
  - Helper functions is_load and is_misaligned.
- One sub-module, mem_load_format: purely combinational lane extraction, extension and LWL/LWR merge; instantiated by mem_access_unit.

Test Plan:
- Memory word 0xBFC00004 = 0x8899AABB, zero wait, LW addr 0xBFC00004 → avm_address 0xBFC00004, byteenable 1111, read high 1 cycle; done in cycle 3, rdata 0x8899AABB, err 0.
- Same word, sub-word loads:
  - LB 0xBFC00007 → byteenable 1000, rdata 0xFFFFFF88.
  - LBU 0xBFC00007 → rdata 0x00000088.
  - LH 0xBFC00006 → rdata 0xFFFF8899.
  - LHU 0xBFC00004 → rdata 0x0000AABB.
- SB 0xBFC00009 with wdata 0x12345678 → address 0xBFC00008, byteenable 0010, writedata 0x78787878, done in cycle 2; a following LW of 0xBFC00008 shows byte 1 = 0x78 and the other bytes unchanged.
- LW with waitrequest high for 3 cycles → read, address and byteenable stable for 4 cycles; done in cycle 6 with the correct rdata.
- LH 0xBFC00005, and SW 0xBFC00002 → done=1 and err=1 in cycle 1; avm_read and avm_write never asserted; rdata unchanged.
- Reset asserted while WRITE is stalled → next cycle avm_write=0 and done=0; a following SW completes normally.
- With MEM_ACCESS_LWLR_EN, addr 0xBFC00005, rt_old 0x11223344 → LWL gives 0xAABB3344, LWR gives 0x118899AA. Without the macro, both give err=1.
